ex_muldiv_stage: RTL
====================

// Module: ex_muldiv_stage
// PURPOSE
//  EX-stage operand front end plus iterative multiply/divide unit with HI/LO registers.
//  Selects operand_a/operand_b from the register file, EX/MEM or MEM/WB using the
//  forwardA/forwardB codes from the forwarding unit, and feeds the ALU.
//  Runs MULT/MULTU/DIV/DIVU over multiple cycles.
//  Raises stall_ex so hazard control holds IF/ID/ID-EX while HI/LO results are pending.
// PARAMETERS
//  WIDTH      32  datapath width (HI/LO each WIDTH bits)
//  ITER       32  iteration cycles per mul/div (must equal WIDTH)
// PORTS
//  clk                   in   1      rising-edge clock
//  rst_n                 in   1      synchronous, active-low reset
//  forwardA              in   2      00 regfile, 10 EX/MEM, 01 MEM/WB, 11 = regfile
//  forwardB              in   2      same encoding for rt operand
//  rs_data_idex          in   WIDTH  rs value from ID/EX
//  rt_data_idex          in   WIDTH  rt value from ID/EX
//  alu_result_exmem      in   WIDTH  EX/MEM forwarded result
//  writeback_data_memwb  in   WIDTH  MEM/WB forwarded result
//  md_valid_idex         in   1      ID/EX holds a mul/div instruction
//  md_op_idex            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  mfhi_idex             in   1      ID/EX holds MFHI
//  mflo_idex             in   1      ID/EX holds MFLO
//  operand_a             out  WIDTH  forwarded rs (combinational)
//  operand_b             out  WIDTH  forwarded rt (combinational)
//  hilo_data             out  WIDTH  HI if mfhi, LO if mflo, else 0 (combinational)
//  md_busy               out  1      mul/div in progress (registered)
//  stall_ex              out  1      hold pipeline upstream of EX (combinational)
// BEHAVIOUR
//  Operand mux: purely combinational, with zero cycles of latency.
//   If both forward bits are set (code 11), the regfile value is selected.
//  FSM states: IDLE -> RUN -> FIX -> IDLE. Reset puts the FSM in IDLE.
//   Reset clears HI/LO to 0, the counter to 0 and md_busy to 0.
//   Reset while in RUN or FIX aborts the operation; HI/LO read 0 on the next cycle.
//  Accept: in IDLE with md_valid_idex=1, latch operand_a/operand_b (the forwarded
//   values) and md_op_idex, load counter=ITER-1, then go to RUN. No stall is raised
//   on the accept cycle.
//  RUN: one bit per cycle for ITER cycles. Multiply is shift-add on magnitudes.
//   Divide is restoring division on magnitudes. Signed ops take absolute values
//   at accept.
//  FIX: one cycle. Applies the sign correction and writes HI/LO at the end of the cycle.
//   The FSM then returns to IDLE.
//  md_busy=1 from the cycle after accept through the FIX cycle (ITER+1 cycles).
//  Result visible in HI/LO at accept + ITER + 2 cycles.
//  Mul: {HI,LO} = 2*WIDTH-bit product; signed or unsigned per op.
//  Div: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of
//   the dividend.
//  Divide by zero (any signedness): HI = dividend, LO = all ones. Still takes full latency.
//  Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0.
//  stall_ex = md_busy & (md_valid_idex | mfhi_idex | mflo_idex).
//   A new mul/div issued while busy waits.
//   Because busy is still 1 during FIX, MFHI/MFLO see the new HI/LO on the first
//   unstalled cycle.
//  mfhi_idex and mflo_idex both high: HI takes priority.
//  md_valid_idex while busy is never latched until the FSM is back in IDLE.
//   A held instruction is accepted exactly once.
//  No other operation writes HI/LO (MTHI/MTLO are out of scope).
// TESTING
//  Forwarding: rs=1, exmem=2, memwb=3. Sweep forwardA 00/10/01/11
//   -> operand_a = 1/2/3/1. Repeat on the B side.
//  MULT -3*7 -> md_busy for 33 cycles; HI=FFFFFFFF, LO=FFFFFFEB at accept+34.
//  MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
//   DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//   DIVU 100/0 -> HI=00000064, LO=FFFFFFFF.
//  MFLO issued the cycle after the MULT accept -> stall_ex high 33 cycles.
//   hilo_data then equals the new LO.
//   A back-to-back second MULT is accepted exactly once.
//  rst_n low during RUN cycle 10 -> next cycle md_busy=0, HI=LO=0, stall_ex=0.
//   A new DIV after reset completes correctly.

Source files
------------

// File: rtl/ex_muldiv_stage.sv
// EX-stage operand forwarding mux plus an iterative (one bit per cycle) MULT/MULTU/DIV/DIVU
// unit owning HI/LO. Stalls upstream stages while a result is still pending.
module ex_muldiv_stage #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [WIDTH-1:0] rs_data_idex,
  input  logic [WIDTH-1:0] rt_data_idex,
  input  logic [WIDTH-1:0] alu_result_exmem,
  input  logic [WIDTH-1:0] writeback_data_memwb,
  input  logic             md_valid_idex,
  input  logic [1:0]       md_op_idex,
  input  logic             mfhi_idex,
  input  logic             mflo_idex,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hilo_data,
  output logic             md_busy,
  output logic             stall_ex
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             is_div_q;
  logic             neg_a_q, neg_b_q;
  logic [WIDTH-1:0] a_q, mag_b_q, acc_q, sh_q, hi_q, lo_q;

  // Code 11 falls back to the register file value.
  assign operand_a = (forwardA == 2'b10) ? alu_result_exmem :
                     (forwardA == 2'b01) ? writeback_data_memwb : rs_data_idex;
  assign operand_b = (forwardB == 2'b10) ? alu_result_exmem :
                     (forwardB == 2'b01) ? writeback_data_memwb : rt_data_idex;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  assign sgn_a    = ~md_op_idex[0] & operand_a[WIDTH-1];
  assign sgn_b    = ~md_op_idex[0] & operand_b[WIDTH-1];
  assign mag_a_in = sgn_a ? -operand_a : operand_a;
  assign mag_b_in = sgn_b ? -operand_b : operand_b;

  // acc_q is the running high half (product) or partial remainder (divide);
  // sh_q holds the multiplier being consumed, or the dividend being replaced by quotient bits.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge, div_zero;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mag_b_q} : '0);
  assign div_shift = {acc_q, sh_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
  assign div_zero  = (mag_b_q == '0);
  assign prod      = {acc_q, sh_q};
  assign prod_fix  = (neg_a_q ^ neg_b_q) ? -prod : prod;
  assign quo_fix   = (neg_a_q ^ neg_b_q) ? -sh_q : sh_q;
  assign rem_fix   = neg_a_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (md_valid_idex) begin
            state_q  <= S_RUN;
            cnt_q    <= CW'(ITER - 1);
            busy_q   <= 1'b1;
            is_div_q <= md_op_idex[1];
            neg_a_q  <= sgn_a;
            neg_b_q  <= sgn_b;
            a_q      <= operand_a;
            mag_b_q  <= mag_b_in;
            acc_q    <= '0;
            sh_q     <= mag_a_in;
          end
        end
        S_RUN: begin
          if (!is_div_q) begin
            acc_q <= mul_sum[WIDTH:1];
            sh_q  <= {mul_sum[0], sh_q[WIDTH-1:1]};
          end else if (div_ge) begin
            acc_q <= div_diff;
            sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= div_shift[WIDTH-1:0];
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FIX: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_busy   = busy_q;
  assign stall_ex  = busy_q & (md_valid_idex | mfhi_idex | mflo_idex);
  assign hilo_data = mfhi_idex ? hi_q : (mflo_idex ? lo_q : '0);

endmodule
